lift_call_conditioner: RTL and testbench

//  Conditions the 28 raw push-button lines of the three-car group (car panels, hall up, hall down) before they reach the lift top level.

---
 rtl/lift_call_conditioner.sv | 131 +++++++++++++
 tb/tb_lift_call_conditioner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_call_conditioner.sv
// lift_call_conditioner
// Cleans up the raw push-button lines of the three-car group before they
// reach the lift top level. Every line has its own synchroniser, debounce
// filter, press-pulse generator and stuck-button detector. A line that stays
// pressed for too long is masked from the call inputs and flagged for
// maintenance until the button is released again.
// Bit packing of the lines: [5:0] car1 floors 0-5, [11:6] car2, [17:12] car3,
// [22:18] hall-up floors 0-4, [27:23] hall-down floors 1-5.

module lift_call_conditioner #(
    parameter int N_LINES     = 28,
    parameter int DEB_CNT     = 10,
    parameter int DEB_W       = 4,
    parameter int PRESC       = 1000,
    parameter int PRESC_W     = 10,
    parameter int STUCK_TICKS = 50,
    parameter int STUCK_W     = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LINES-1:0] btn_raw,
    output logic [N_LINES-1:0] btn_level,
    output logic [N_LINES-1:0] btn_pulse,
    output logic [N_LINES-1:0] stuck,
    output logic               any_stuck
);

    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CNT - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
    localparam logic [STUCK_W-1:0] HOLD_MAX   = STUCK_W'(STUCK_TICKS);

    logic [N_LINES-1:0] sync1_q;
    logic [N_LINES-1:0] sync2_q;
    logic [N_LINES-1:0] deb_q;
    logic [N_LINES-1:0] deb_d;
    logic [DEB_W-1:0]   cnt_q  [N_LINES];
    logic [DEB_W-1:0]   cnt_d  [N_LINES];
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick;
    logic [STUCK_W-1:0] hold_q [N_LINES];
    logic [STUCK_W-1:0] hold_d [N_LINES];
    logic [N_LINES-1:0] stuck_q;
    logic [N_LINES-1:0] stuck_d;
    logic [N_LINES-1:0] level_q;
    logic [N_LINES-1:0] level_d;
    logic [N_LINES-1:0] pulse_q;
    logic [N_LINES-1:0] pulse_d;
    logic               any_q;

    // Free-running prescaler; tick marks the last count of each period.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Per-line debounce, hold timer, stuck flag and the registered outputs.
    always_comb begin
        deb_d   = deb_q;
        stuck_d = stuck_q;
        pulse_d = '0;
        level_d = '0;
        for (int i = 0; i < N_LINES; i++) begin
            cnt_d[i]  = '0;
            hold_d[i] = hold_q[i];
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            if (!deb_q[i]) begin
                hold_d[i] = '0;
            end else if (tick && (hold_q[i] != HOLD_MAX)) begin
                hold_d[i] = hold_q[i] + 1'b1;
            end
            if (!deb_d[i]) begin
                stuck_d[i] = 1'b0;
            end else if (hold_d[i] == HOLD_MAX) begin
                stuck_d[i] = 1'b1;
            end
            pulse_d[i] = deb_d[i] & ~deb_q[i] & ~stuck_q[i];
            level_d[i] = deb_d[i] & ~stuck_d[i];
        end
    end

    // Two-flop synchroniser on the asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Filter, timer and output state; a held button re-qualifies after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q   <= '0;
            presc_q <= '0;
            stuck_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N_LINES; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            deb_q   <= deb_d;
            presc_q <= presc_d;
            stuck_q <= stuck_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            any_q   <= |stuck_q;
            for (int i = 0; i < N_LINES; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;
    assign stuck     = stuck_q;
    assign any_stuck = any_q;

endmodule

// File: tb/tb_lift_call_conditioner.sv
// tb_lift_call_conditioner
// Self-checking bench for the button conditioner with small debounce and
// stuck-timer parameters. A cycle-level reference model feeds a scoreboard
// that is compared every clock, and directed sequences check latencies.

module tb_lift_call_conditioner;

    localparam int N       = 28;
    localparam int DEB_CNT = 4;
    localparam int PRESC   = 8;
    localparam int ST      = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;
    logic [N-1:0] stuck;
    logic         any_stuck;

    lift_call_conditioner #(
        .N_LINES(N), .DEB_CNT(DEB_CNT), .DEB_W(3), .PRESC(PRESC),
        .PRESC_W(3), .STUCK_TICKS(ST), .STUCK_W(2)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_pulse(btn_pulse), .stuck(stuck), .any_stuck(any_stuck)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] level;
        logic [N-1:0] pulse;
        logic [N-1:0] stk;
        logic         any;
    } expT;

    typedef struct {
        int line;
        int highLen;
        int expPulses;
    } glitchT;

    expT expQ[$];
    int  errors = 0;
    int  checks = 0;
    int  edgeNum = 0;

    // Reference model state
    logic [N-1:0] mS1 = '0, mS2 = '0, mDeb = '0, mStuck = '0, mLevel = '0, mPulse = '0;
    logic         mAny = 1'b0;
    int           mRun[N];
    int           mTicks[N];
    int           mPresc = 0;

    // Event trackers, first occurrence since the last clearTrack
    int           firstPulse[N], pulseCnt[N], levelRise[N], levelFall[N];
    int           stuckRise[N], stuckFall[N];
    int           anyRise;
    logic [N-1:0] prevLevel = '0, prevStuck = '0;
    logic         prevAny = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeNum, act, exp);
        end
    endtask

    task automatic clearTrack();
        for (int i = 0; i < N; i++) begin
            firstPulse[i] = -1; pulseCnt[i] = 0; levelRise[i] = -1;
            levelFall[i] = -1; stuckRise[i] = -1; stuckFall[i] = -1;
        end
        anyRise = -1;
    endtask

    // Behaviour of one rising edge: deb flips after DEB_CNT consecutive edges
    // of disagreement, stuck after ST prescaler ticks of a debounced press.
    task automatic modelStep();
        logic [N-1:0] nDeb, nStuck;
        logic         tickNow;
        int           nTicks;
        if (reset) begin
            mS1 = '0; mS2 = '0; mDeb = '0; mStuck = '0; mLevel = '0; mPulse = '0;
            mAny = 1'b0; mPresc = 0;
            for (int i = 0; i < N; i++) begin mRun[i] = 0; mTicks[i] = 0; end
        end else begin
            tickNow = (mPresc == PRESC - 1);
            nDeb = mDeb;
            nStuck = '0;
            for (int i = 0; i < N; i++) begin
                if (mS2[i] != mDeb[i]) begin
                    mRun[i] = mRun[i] + 1;
                    if (mRun[i] == DEB_CNT) begin
                        nDeb[i] = mS2[i];
                        mRun[i] = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
                if (!mDeb[i]) nTicks = 0;
                else if (tickNow && mTicks[i] < ST) nTicks = mTicks[i] + 1;
                else nTicks = mTicks[i];
                mTicks[i] = nTicks;
                nStuck[i] = nDeb[i] && (mStuck[i] || nTicks >= ST);
                mPulse[i] = nDeb[i] && !mDeb[i] && !mStuck[i];
                mLevel[i] = nDeb[i] && !nStuck[i];
            end
            mAny   = |mStuck;
            mStuck = nStuck;
            mDeb   = nDeb;
            mPresc = tickNow ? 0 : mPresc + 1;
            mS2    = mS1;
            mS1    = btn_raw;
        end
    endtask

    // One clock: predict, push, let the edge happen, pop and compare.
    task automatic cycle();
        expT e;
        modelStep();
        expQ.push_back('{mLevel, mPulse, mStuck, mAny});
        @(posedge clk);
        #1;
        edgeNum++;
        e = expQ.pop_front();
        checkOutput("sbLevel", 32'(btn_level), 32'(e.level));
        checkOutput("sbPulse", 32'(btn_pulse), 32'(e.pulse));
        checkOutput("sbStuck", 32'(stuck), 32'(e.stk));
        checkOutput("sbAny", 32'(any_stuck), 32'(e.any));
        for (int i = 0; i < N; i++) begin
            if (btn_pulse[i]) begin
                pulseCnt[i]++;
                if (firstPulse[i] < 0) firstPulse[i] = edgeNum;
            end
            if (btn_level[i] && !prevLevel[i] && levelRise[i] < 0) levelRise[i] = edgeNum;
            if (!btn_level[i] && prevLevel[i] && levelFall[i] < 0) levelFall[i] = edgeNum;
            if (stuck[i] && !prevStuck[i] && stuckRise[i] < 0) stuckRise[i] = edgeNum;
            if (!stuck[i] && prevStuck[i] && stuckFall[i] < 0) stuckFall[i] = edgeNum;
        end
        if (any_stuck && !prevAny && anyRise < 0) anyRise = edgeNum;
        prevLevel = btn_level;
        prevStuck = stuck;
        prevAny   = any_stuck;
    endtask

    task automatic applyStimulus(input logic [N-1:0] raw, input logic rst, input int n);
        btn_raw = raw;
        reset   = rst;
        for (int k = 0; k < n; k++) cycle();
    endtask

    glitchT glitchTab[6];

    initial begin
        int e, d, s, r, x, a, others;
        logic [N-1:0] oneHot;

        glitchTab[0] = '{7, 3, 0};
        glitchTab[1] = '{7, 4, 1};
        glitchTab[2] = '{8, 1, 0};
        glitchTab[3] = '{9, 2, 0};
        glitchTab[4] = '{10, 5, 1};
        glitchTab[5] = '{11, 3, 0};

        clearTrack();
        applyStimulus('0, 1'b1, 3);
        checkOutput("rstLevel", 32'(btn_level), 32'd0);
        checkOutput("rstPulse", 32'(btn_pulse), 32'd0);
        checkOutput("rstStuck", 32'(stuck), 32'd0);
        checkOutput("rstAny", 32'(any_stuck), 32'd0);
        applyStimulus('0, 1'b0, 6);

        // Single press on line 0
        clearTrack();
        e = edgeNum + 1;
        applyStimulus(28'h1, 1'b0, 12);
        checkOutput("p0PulseEdge", 32'(firstPulse[0]), 32'(e + 5));
        checkOutput("p0LevelEdge", 32'(levelRise[0]), 32'(e + 5));
        checkOutput("p0PulseCount", 32'(pulseCnt[0]), 32'd1);
        others = 0;
        for (int i = 1; i < N; i++) others += pulseCnt[i];
        checkOutput("p0OtherPulses", 32'(others), 32'd0);
        checkOutput("p0LevelWord", 32'(btn_level), 32'h1);
        applyStimulus('0, 1'b0, 10);

        // Glitch table: short highs are filtered, DEB_CNT-long highs pass
        for (int g = 0; g < 6; g++) begin
            clearTrack();
            oneHot = N'(1) << glitchTab[g].line;
            applyStimulus(oneHot, 1'b0, glitchTab[g].highLen);
            applyStimulus('0, 1'b0, 12);
            checkOutput("glitchPulses", 32'(pulseCnt[glitchTab[g].line]), 32'(glitchTab[g].expPulses));
            checkOutput("glitchLevel", 32'(levelRise[glitchTab[g].line] >= 0), 32'(glitchTab[g].expPulses));
        end

        // Simultaneous presses on a car and two hall lines
        clearTrack();
        e = edgeNum + 1;
        applyStimulus((N'(1) << 2) | (N'(1) << 19) | (N'(1) << 27), 1'b0, 10);
        checkOutput("simPulse2", 32'(firstPulse[2]), 32'(e + 5));
        checkOutput("simPulse19", 32'(firstPulse[19]), 32'(e + 5));
        checkOutput("simPulse27", 32'(firstPulse[27]), 32'(e + 5));
        checkOutput("simPulseCount", 32'(pulseCnt[2] + pulseCnt[19] + pulseCnt[27]), 32'd3);
        applyStimulus('0, 1'b0, 10);

        // Stuck button on line 5
        clearTrack();
        e = edgeNum + 1;
        applyStimulus(N'(1) << 5, 1'b0, 40);
        r = edgeNum + 1;
        applyStimulus('0, 1'b0, 10);
        d = levelRise[5];
        s = stuckRise[5];
        checkOutput("stkDebEdge", 32'(d), 32'(e + 5));
        checkOutput("stkWindow", 32'((s - d) >= 17 && (s - d) <= 25), 32'd1);
        checkOutput("stkLevelFall", 32'(levelFall[5]), 32'(s));
        checkOutput("stkAnyEdge", 32'(anyRise), 32'(s + 1));
        checkOutput("stkClearEdge", 32'(stuckFall[5]), 32'(r + 5));
        checkOutput("stkPulseCount", 32'(pulseCnt[5]), 32'd1);

        // Reset while line 3 is held and debounced
        applyStimulus(N'(1) << 3, 1'b0, 10);
        applyStimulus(N'(1) << 3, 1'b1, 1);
        x = edgeNum;
        checkOutput("midRstLevel", 32'(btn_level), 32'd0);
        checkOutput("midRstPulse", 32'(btn_pulse), 32'd0);
        checkOutput("midRstAny", 32'({stuck, any_stuck}), 32'd0);
        clearTrack();
        applyStimulus(N'(1) << 3, 1'b0, 10);
        checkOutput("midRstPulseEdge", 32'(firstPulse[3]), 32'(x + 6));
        checkOutput("midRstPulseCount", 32'(pulseCnt[3]), 32'd1);
        applyStimulus('0, 1'b0, 10);

        // Bouncing release on line 1
        applyStimulus(N'(1) << 1, 1'b0, 10);
        clearTrack();
        a = edgeNum + 1;
        applyStimulus('0, 1'b0, 1);
        applyStimulus(N'(1) << 1, 1'b0, 1);
        applyStimulus('0, 1'b0, 1);
        applyStimulus(N'(1) << 1, 1'b0, 1);
        applyStimulus('0, 1'b0, 12);
        checkOutput("bounceFallEdge", 32'(levelFall[1]), 32'(a + 9));
        checkOutput("bounceNoPulse", 32'(pulseCnt[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
